serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_tx_pkg.sv | 9 +
 rtl/serial_word_tx.sv | 50 +++++
 tb/tb_serial_word_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared constants and state type for the serial word transmitter
package serial_tx_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-in, LSB-first serial-out word transmitter with back-to-back loading
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             ser_last,
    output logic             ser_valid
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0] bit_cnt;
    logic last, accept;
    always_comb begin
        last = bit_cnt == CW'(WIDTH - 1);
        in_ready = !rst && (state == IDLE || (last && ser_en));
        accept = in_valid && in_ready;
        state_nx = accept ? SHIFT : (state == SHIFT && last && ser_en) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Counter parks at 0 after the last bit so idle state never carries a stale count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            sreg <= in_data;
            bit_cnt <= '0;
        end else if (state == SHIFT && ser_en) begin
            sreg <= sreg >> 1;
            bit_cnt <= last ? '0 : bit_cnt + CW'(1);
        end
    end
    assign ser_valid = state == SHIFT;
    assign ser_bit = ser_valid && sreg[0];
    assign ser_start = ser_valid && bit_cnt == '0;
    assign ser_last = ser_valid && last;
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed self-checking bench for serial_word_tx
module tb_serial_word_tx;
    logic clk = 0, rst = 1, in_valid = 0, ser_en = 1;
    logic [7:0] in_data = '0;
    logic in_ready, ser_bit, ser_start, ser_last, ser_valid;
    int checks = 0, errors = 0, gi = 0;
    logic [31:0] gb, gs, gl, gv, gr;
    logic seen;
    logic [7:0] nacc;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ser_en(ser_en), .ser_bit(ser_bit), .ser_start(ser_start), .ser_last(ser_last),
        .ser_valid(ser_valid)
    );

    // Serial two's-complement negator: pass bits up to and including the first 1, invert the rest.
    always @(posedge clk) if (ser_valid && ser_en) begin
        seen <= ser_start ? ser_bit : (seen | ser_bit);
        nacc <= {ser_start ? ser_bit : (seen ? ~ser_bit : ser_bit), nacc[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        gb = '0; gs = '0; gl = '0; gv = '0; gr = '0; gi = 0;
    endtask

    task automatic cap(input int n);
        for (int i = 0; i < n; i++) begin
            gb[gi] = ser_bit; gs[gi] = ser_start; gl[gi] = ser_last;
            gv[gi] = ser_valid; gr[gi] = in_ready;
            gi++;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_outs", 32'({ser_valid, ser_bit, ser_start, ser_last}), 0);
        @(negedge clk);
        rst = 0;
        #1 chk("rel_ready", 32'(in_ready), 1);
        @(negedge clk);

        in_valid = 1; in_data = 8'hB5;
        @(negedge clk);
        in_valid = 0;
        clr(); cap(9);
        chk("single_bits", gb, 32'h0B5);
        chk("single_start", gs, 32'h001);
        chk("single_last", gl, 32'h080);
        chk("single_valid", gv, 32'h0FF);
        chk("single_ready", gr, 32'h180);

        in_valid = 1; in_data = 8'hB5;
        @(negedge clk);
        in_data = 8'h01;
        clr(); cap(8);
        in_valid = 0;
        cap(9);
        chk("b2b_bits", gb, 32'h001B5);
        chk("b2b_start", gs, 32'h00101);
        chk("b2b_last", gl, 32'h08080);
        chk("b2b_valid", gv, 32'h0FFFF);
        chk("b2b_ready", gr, 32'h18080);

        in_valid = 1; in_data = 8'hB5;
        @(negedge clk);
        in_valid = 0;
        clr(); cap(3);
        ser_en = 0;
        cap(3);
        ser_en = 1;
        cap(6);
        chk("stall_bits", gb, 32'h585);
        chk("stall_start", gs, 32'h001);
        chk("stall_last", gl, 32'h400);
        chk("stall_valid", gv, 32'h7FF);
        chk("stall_ready", gr, 32'hC00);

        in_valid = 1; in_data = 8'hFF;
        @(negedge clk);
        in_valid = 0; in_data = 8'h00;
        clr(); cap(9);
        chk("inchg_bits", gb, 32'h0FF);
        chk("inchg_valid", gv, 32'h0FF);

        in_valid = 1; in_data = 8'h05;
        @(negedge clk);
        in_valid = 0;
        repeat (8) @(negedge clk);
        chk("loop_neg", 32'(nacc), 32'hFB);

        in_valid = 1; in_data = 8'hB5;
        @(negedge clk);
        in_valid = 0;
        repeat (2) @(negedge clk);
        chk("mid_valid", 32'(ser_valid), 1);
        rst = 1;
        #1 chk("arst_outs", 32'({ser_valid, ser_bit, ser_start, ser_last}), 0);
        chk("arst_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        chk("hold_ready", 32'(in_ready), 0);
        rst = 0;
        @(negedge clk);
        chk("post_ready", 32'(in_ready), 1);
        chk("post_outs", 32'({ser_valid, ser_bit, ser_start, ser_last}), 0);
        @(negedge clk);
        chk("post_valid2", 32'(ser_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
